// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low [6:0]=g..a patterns and the digit value type.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG7_PAT_0     = 7'h40;
  localparam logic [6:0] SEG7_PAT_1     = 7'h79;
  localparam logic [6:0] SEG7_PAT_2     = 7'h24;
  localparam logic [6:0] SEG7_PAT_3     = 7'h30;
  localparam logic [6:0] SEG7_PAT_4     = 7'h19;
  localparam logic [6:0] SEG7_PAT_5     = 7'h12;
  localparam logic [6:0] SEG7_PAT_6     = 7'h02;
  localparam logic [6:0] SEG7_PAT_7     = 7'h78;
  localparam logic [6:0] SEG7_PAT_8     = 7'h00;
  localparam logic [6:0] SEG7_PAT_9     = 7'h10;
  localparam logic [6:0] SEG7_PAT_A     = 7'h08;
  localparam logic [6:0] SEG7_PAT_B     = 7'h03;
  localparam logic [6:0] SEG7_PAT_C     = 7'h46;
  localparam logic [6:0] SEG7_PAT_D     = 7'h21;
  localparam logic [6:0] SEG7_PAT_E     = 7'h06;
  localparam logic [6:0] SEG7_PAT_F     = 7'h0E;
  localparam logic [6:0] SEG7_PAT_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low 7-segment pattern to digit value decoder.
// SEG_DECODE_HEX_EN: when defined, patterns A..F decode to 10..15 instead of being unknown.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       blank,
  output logic       unknown
);

  always_comb begin
    value   = 4'd0;
    blank   = 1'b0;
    unknown = 1'b0;
    case (pattern)
      SEG7_PAT_0:     value = 4'd0;
      SEG7_PAT_1:     value = 4'd1;
      SEG7_PAT_2:     value = 4'd2;
      SEG7_PAT_3:     value = 4'd3;
      SEG7_PAT_4:     value = 4'd4;
      SEG7_PAT_5:     value = 4'd5;
      SEG7_PAT_6:     value = 4'd6;
      SEG7_PAT_7:     value = 4'd7;
      SEG7_PAT_8:     value = 4'd8;
      SEG7_PAT_9:     value = 4'd9;
`ifdef SEG_DECODE_HEX_EN
      SEG7_PAT_A:     value = 4'hA;
      SEG7_PAT_B:     value = 4'hB;
      SEG7_PAT_C:     value = 4'hC;
      SEG7_PAT_D:     value = 4'hD;
      SEG7_PAT_E:     value = 4'hE;
      SEG7_PAT_F:     value = 4'hF;
`endif
      SEG7_PAT_BLANK: blank = 1'b1;
      default:        unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus, captures each settled scan slot into a per-digit register file.
// Hex digit support follows SEG_DECODE_HEX_EN through seg7_pattern_decode.
module seven_segment_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_strobe,
  output logic                    frame_valid,
  output logic                    decode_err
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [7:0]            seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0] dig_s1, dig_s2, dig_prev;
  logic [CW-1:0]         stable_cnt;
  logic [TW-1:0]         to_cnt;
  logic [NUM_DIGITS-1:0] seen, seen_set;
  logic [IW-1:0]         idx;
  logic                  same, one_hot, capture;
  digit_t                dec_value;
  logic                  dec_blank, dec_unknown;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
      dig_s1   <= '1;
      dig_s2   <= '1;
      dig_prev <= '1;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      dig_s1   <= dig_en_n;
      dig_s2   <= dig_s1;
      dig_prev <= dig_s2;
    end
  end

  assign same    = (seg_s2 == seg_prev) && (dig_s2 == dig_prev);
  assign one_hot = $onehot(~dig_s2);
  // Counter saturates, so the SETTLE-2 -> SETTLE-1 step happens once per stable period.
  assign capture = same && one_hot && (stable_cnt == CW'(SETTLE_CYCLES - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
    end else if (!same) begin
      stable_cnt <= '0;
    end else if (stable_cnt != CW'(SETTLE_CYCLES - 1)) begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!dig_s2[i]) idx = IW'(i);
    end
  end

  always_comb begin
    seen_set      = seen;
    seen_set[idx] = 1'b1;
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_s2[6:0]),
    .value   (dec_value),
    .blank   (dec_blank),
    .unknown (dec_unknown)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_bcd    <= '0;
      digit_blank  <= '1;
      frame_strobe <= 1'b0;
      frame_valid  <= 1'b0;
      decode_err   <= 1'b0;
      seen         <= '0;
      to_cnt       <= '0;
    end else begin
      frame_strobe <= 1'b0;
      // A new error in the same cycle overrides the clear below.
      if (err_clr) decode_err <= 1'b0;
      if (capture) begin
        to_cnt <= '0;
        if (dec_unknown) begin
          decode_err <= 1'b1;
        end else if (dec_blank) begin
          digit_blank[idx] <= 1'b1;
        end else begin
          digit_bcd[{idx, 2'b00} +: 4] <= dec_value;
          digit_blank[idx]             <= 1'b0;
        end
        if (&seen_set) begin
          frame_strobe <= 1'b1;
          frame_valid  <= 1'b1;
          seen         <= '0;
        end else begin
          seen <= seen_set;
        end
      end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_valid <= 1'b0;
        seen        <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for seven_segment_scan_decoder (SETTLE_CYCLES=16, TIMEOUT_CYCLES=64).
module tb_seven_segment_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_in;
  logic [7:0]  dig_en_n;
  logic        err_clr;
  logic [31:0] digit_bcd;
  logic [7:0]  digit_blank;
  logic        frame_strobe;
  logic        frame_valid;
  logic        decode_err;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int strobe_base;

  // Active-low patterns with dp off, index = digit value.
  logic [7:0] pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seven_segment_scan_decoder #(
    .NUM_DIGITS     (8),
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .dig_en_n     (dig_en_n),
    .err_clr      (err_clr),
    .digit_bcd    (digit_bcd),
    .digit_blank  (digit_blank),
    .frame_strobe (frame_strobe),
    .frame_valid  (frame_valid),
    .decode_err   (decode_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_strobe) strobes++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one slot at a negedge and hold it for n cycles.
  task automatic slot(input logic [7:0] dig, input logic [7:0] seg, input int n);
    dig_en_n = dig;
    seg_in   = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    slot(8'hFF, 8'hFF, n);
  endtask

  initial begin
    rst_n    = 1'b0;
    seg_in   = 8'hFF;
    dig_en_n = 8'hFF;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd",    digit_bcd,    32'h0);
    check("rst_blank",  digit_blank,  32'hFF);
    check("rst_strobe", frame_strobe, 32'h0);
    check("rst_valid",  frame_valid,  32'h0);
    check("rst_err",    decode_err,   32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Slots one sample short of settling never capture.
    strobe_base = strobes;
    for (int i = 0; i < 8; i++) slot(~(8'd1 << i), pat[i+1], 15);
    idle(20);
    check("short_bcd",    digit_bcd,             32'h0);
    check("short_blank",  digit_blank,           32'hFF);
    check("short_strobe", strobes - strobe_base, 32'd0);

    // Full scan, digit i shows i+1.
    strobe_base = strobes;
    for (int i = 0; i < 8; i++) slot(~(8'd1 << i), pat[i+1], 20);
    idle(3);
    check("scan_bcd",    digit_bcd,             32'h87654321);
    check("scan_blank",  digit_blank,           32'h0);
    check("scan_strobe", strobes - strobe_base, 32'd1);
    check("scan_valid",  frame_valid,           32'h1);
    check("scan_err",    decode_err,            32'h0);

    // Unknown pattern on digit 3, then clear.
    slot(8'hF7, 8'hC7, 20);
    check("unk_err",    decode_err,        32'h1);
    check("unk_digit3", digit_bcd[15:12],  32'h4);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    idle(2);
    check("errclr", decode_err, 32'h0);

    // Two digits enabled at once never capture; then blank on digit 2.
    strobe_base = strobes;
    slot(8'hFC, 8'hC0, 100);
    check("twohot_bcd",    digit_bcd,             32'h87654321);
    check("twohot_strobe", strobes - strobe_base, 32'd0);
    slot(8'hFB, 8'hFF, 20);
    check("blank_mask",   digit_blank,      32'h04);
    check("blank_digit2", digit_bcd[11:8],  32'h3);

    // Full frame, digit i shows 9-i, then let the scan stop.
    strobe_base = strobes;
    for (int i = 0; i < 8; i++) slot(~(8'd1 << i), pat[9-i], 20);
    idle(2);
    check("f2_bcd",    digit_bcd,             32'h23456789);
    check("f2_strobe", strobes - strobe_base, 32'd1);
    check("f2_valid",  frame_valid,           32'h1);
    idle(38);
    check("to_early_valid", frame_valid, 32'h1);
    idle(30);
    check("to_valid", frame_valid, 32'h0);
    check("to_bcd",   digit_bcd,   32'h23456789);
    check("to_blank", digit_blank, 32'h0);

    // Hex pattern A on digit 0.
    slot(8'hFE, 8'h88, 20);
`ifdef SEG_DECODE_HEX_EN
    check("hex_digit0", digit_bcd[3:0], 32'hA);
    check("hex_err",    decode_err,     32'h0);
`else
    check("hex_digit0", digit_bcd[3:0], 32'h9);
    check("hex_err",    decode_err,     32'h1);
`endif

    // Reset mid-slot, then a full settle period is needed.
    dig_en_n = 8'hFD;
    seg_in   = pat[1];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_bcd",   digit_bcd,   32'h0);
    check("mid_rst_valid", frame_valid, 32'h0);
    check("mid_rst_err",   decode_err,  32'h0);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_early", digit_bcd, 32'h0);
    repeat (5) @(negedge clk);
    check("post_rst_cap", digit_bcd, 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
